// File: rtl/regfile_mp_pkg.sv
// Shared types and constants for the multi-port register file and its clear sequencer.
package regfile_mp_pkg;

    typedef enum logic {RF_CLEAR, RF_IDLE} rf_state_t;

    localparam int RF_ZERO_ADDR = 0;

    function automatic int addr_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: zeroes entries 1..NUM_REG-1, one per cycle, after reset or on clr_req.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RF_CLEAR | zeroing rf[cnt] each edge; user writes ignored, reads 0
// RF_IDLE  | normal operation; clr_req restarts the clear at entry 1
module regfile_clr_seq
    import regfile_mp_pkg::*;
#(
    parameter  int NUM_REG = 32,
    localparam int AW      = addr_width(NUM_REG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          busy,
    output logic          clr_done
);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RF_CLEAR;
            cnt_q   <= AW'(1);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Entry 0 is never stored-to, so the sweep starts at 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            RF_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(NUM_REG - 1)) begin
                    state_d = RF_IDLE;
                    done_d  = 1'b1;
                end
            end
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    cnt_d   = AW'(1);
                end
            end
        endcase
    end

    assign busy     = (state_q == RF_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt_q;
    assign clr_done = done_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file, r0 hardwired to zero, hardware clear sequencer.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int NUM_REG = 32,
    parameter  int WIDTH   = 32,
    parameter  int NUM_RD  = 2,
    parameter  int NUM_WR  = 2,
    localparam int AW      = addr_width(NUM_REG)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_WR-1:0]       we,
    input  logic [NUM_WR*AW-1:0]    wa,
    input  logic [NUM_WR*WIDTH-1:0] wd,
    input  logic [NUM_RD*AW-1:0]    ra,
    output logic [NUM_RD*WIDTH-1:0] rd,
    input  logic                    clr_req,
    output logic                    busy,
    output logic                    clr_done
);

    logic [WIDTH-1:0] rf [NUM_REG];
    logic             clr_we;
    logic [AW-1:0]    clr_addr;

    regfile_clr_seq #(.NUM_REG(NUM_REG)) u_clr_seq (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy),
        .clr_done (clr_done)
    );

    // Ascending port order makes the highest-index port's assignment win.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            rf[clr_addr] <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (we[i] && (wa[i*AW +: AW] != AW'(RF_ZERO_ADDR)))
                    rf[wa[i*AW +: AW]] <= wd[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        logic [AW-1:0] ra_j;
        rd   = '0;
        ra_j = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            ra_j = ra[j*AW +: AW];
            if (!busy && (ra_j != AW'(RF_ZERO_ADDR))) begin
                rd[j*WIDTH +: WIDTH] = rf[ra_j];
`ifdef REGFILE_MP_BYPASS_EN
                for (int i = 0; i < NUM_WR; i++) begin
                    if (we[i] && (wa[i*AW +: AW] == ra_j))
                        rd[j*WIDTH +: WIDTH] = wd[i*WIDTH +: WIDTH];
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected values, a negedge monitor checks them.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic        clr_req;
    logic        busy;
    logic        clr_done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0]  sig;   // 0 rd0, 1 rd1, 2 busy, 3 clr_done
        logic [15:0] tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    regfile_mp dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .ra       (ra),
        .rd       (rd),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done)
    );

    always #5 clk = ~clk;

    function automatic string sig_name(input logic [1:0] s);
        case (s)
            2'd0:    return "rd0";
            2'd1:    return "rd1";
            2'd2:    return "busy";
            default: return "clr_done";
        endcase
    endfunction

    // Monitor: outputs are stable between edges; check everything queued for this cycle.
    always @(negedge clk) begin
        exp_t       e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sig)
                2'd0:    act = rd[31:0];
                2'd1:    act = rd[63:32];
                2'd2:    act = {31'd0, busy};
                default: act = {31'd0, clr_done};
            endcase
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s tag=%0d actual=%h required=%h", sig_name(e.sig), e.tag, act, e.exp);
            end
        end
    end

    task automatic expect_val(input logic [1:0] sig, input int tag, input logic [31:0] v);
        sb.push_back('{sig: sig, tag: 16'(tag), exp: v});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] w, input logic [4:0] a1, input logic [4:0] a0,
                         input logic [31:0] d1, input logic [31:0] d0,
                         input logic [4:0] r1, input logic [4:0] r0);
        we = w;
        wa = {a1, a0};
        wd = {d1, d0};
        ra = {r1, r0};
    endtask

    function automatic logic [31:0] fill_val(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Cycles 1..31 busy, cycle 32 idle with clr_done, then quiet. Optional probes inside.
    task automatic clear_window(input int tid, input bit probes);
        for (int k = 1; k <= 35; k++) begin
            clr_req = 1'b0;
            drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd17, 5'd5);
            if (probes) begin
                ra = {5'd17, 5'd4};
                if (k == 10) drive(2'b01, 5'd0, 5'd4, 32'd0, 32'hBAD0_0004, 5'd17, 5'd4);
                if (k == 5)  clr_req = 1'b1;
            end
            expect_val(2, tid*100 + k, (k <= 31) ? 32'd1 : 32'd0);
            expect_val(3, tid*100 + k, (k == 32) ? 32'd1 : 32'd0);
            if (k <= 31) begin
                expect_val(0, tid*100 + k, 32'd0);
                expect_val(1, tid*100 + k, 32'd0);
            end
            cyc();
        end
    endtask

    initial begin
        reset   = 1'b0;
        clr_req = 1'b0;
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd5);

        // Reset held: sequencer parked in clear, reads forced to zero.
        for (int k = 0; k < 3; k++) begin
            expect_val(2, 100 + k, 32'd1);
            expect_val(3, 100 + k, 32'd0);
            expect_val(0, 100 + k, 32'd0);
            cyc();
        end
        reset = 1'b1;
        clear_window(2, 1'b0);

        // Port0 writes r3, port1 tries r0.
        drive(2'b11, 5'd0, 5'd3, 32'hFFFF_FFFF, 32'h0000_1234, 5'd0, 5'd3);
`ifdef REGFILE_MP_BYPASS_EN
        expect_val(0, 301, 32'h0000_1234);
`else
        expect_val(0, 301, 32'd0);
`endif
        expect_val(1, 301, 32'd0);
        cyc();
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd3);
        expect_val(0, 302, 32'h0000_1234);
        expect_val(1, 302, 32'd0);
        expect_val(3, 302, 32'd0);
        cyc();

        // Both ports hit r7: port1 must win.
        drive(2'b11, 5'd7, 5'd7, 32'h5555_5555, 32'hAAAA_AAAA, 5'd0, 5'd7);
`ifdef REGFILE_MP_BYPASS_EN
        expect_val(0, 401, 32'h5555_5555);
`else
        expect_val(0, 401, 32'd0);
`endif
        cyc();
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd7);
        expect_val(0, 402, 32'h5555_5555);
        cyc();

        // r9 old value, then port1 writes DEADBEEF while ra1 looks at r9.
        drive(2'b01, 5'd0, 5'd9, 32'd0, 32'h1111_1111, 5'd0, 5'd0);
        cyc();
        drive(2'b10, 5'd9, 5'd9, 32'hDEAD_BEEF, 32'h7777_7777, 5'd9, 5'd0);
`ifdef REGFILE_MP_BYPASS_EN
        expect_val(1, 501, 32'hDEAD_BEEF);
`else
        expect_val(1, 501, 32'h1111_1111);
`endif
        cyc();
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd0);
        expect_val(1, 502, 32'hDEAD_BEEF);
        cyc();

        // Fill r1..r31 two per cycle, then read back.
        for (int i = 1; i <= 31; i += 2) begin
            drive((i < 31) ? 2'b11 : 2'b01, 5'(i + 1), 5'(i), fill_val(i + 1), fill_val(i), 5'd0, 5'd0);
            cyc();
        end
        for (int i = 1; i <= 31; i += 2) begin
            drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'(i + 1), 5'(i));
            expect_val(0, 600 + i, fill_val(i));
            expect_val(1, 600 + i, (i < 31) ? fill_val(i + 1) : 32'd0);
            cyc();
        end

        // Request clear; write to r4 and repeated clr_req while busy must be ignored.
        drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        clr_req = 1'b1;
        expect_val(2, 700, 32'd0);
        cyc();
        clear_window(7, 1'b1);
        for (int i = 1; i <= 31; i += 2) begin
            drive(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'(i + 1), 5'(i));
            expect_val(0, 800 + i, 32'd0);
            expect_val(1, 800 + i, 32'd0);
            cyc();
        end

        // Reset at clear cycle 10: aborted sequence gives no clr_done, new one is full length.
        clr_req = 1'b1;
        expect_val(2, 900, 32'd0);
        cyc();
        clr_req = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            expect_val(2, 900 + k, 32'd1);
            expect_val(3, 900 + k, 32'd0);
            cyc();
        end
        reset = 1'b0;
        for (int k = 10; k <= 11; k++) begin
            expect_val(2, 900 + k, 32'd1);
            expect_val(3, 900 + k, 32'd0);
            cyc();
        end
        reset = 1'b1;
        clear_window(10, 1'b0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
